// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : One-at-a-time load/store stage with range checking, splitting of
//            misaligned accesses into two aligned words, and load extension.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 32'h0001_0000,
    parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 32'h0001_FFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_fault_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_acc1 = 3'd1;
    localparam logic [2:0] c_st_acc2 = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_resp = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;

    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [7:0]              r_mask;
    logic [2*DATA_WIDTH-1:0] r_lanes;
    logic                    r_fault;
    logic                    r_split;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_hi;

    logic                    w_accept;
    logic [2:0]              w_nbytes;
    logic [DATA_WIDTH:0]     w_last_addr;
    logic                    w_fault;
    logic [3:0]              w_span;
    logic                    w_split;
    logic [7:0]              w_mask_base;
    logic [7:0]              w_mask;
    logic [2*DATA_WIDTH-1:0] w_lanes;
    logic [DATA_WIDTH-1:0]   w_word_addr;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load;
    logic                    w_sext;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the live request, used at accept)
    // ------------------------------------------------------------------
    assign w_accept = (r_state == c_st_idle) && req_valid_i;

    always_comb begin
        w_nbytes    = 3'd4;
        w_mask_base = 8'h0F;
        case (req_size_i)
            2'b00: begin
                w_nbytes    = 3'd1;
                w_mask_base = 8'h01;
            end
            2'b01: begin
                w_nbytes    = 3'd2;
                w_mask_base = 8'h03;
            end
            default: begin
                w_nbytes    = 3'd4;
                w_mask_base = 8'h0F;
            end
        endcase
    end

    // One extra bit keeps the end-of-access sum from wrapping past the top of memory
    assign w_last_addr = {1'b0, req_addr_i} + {{(DATA_WIDTH-2){1'b0}}, w_nbytes}
                         - (DATA_WIDTH+1)'(1);
    assign w_fault     = (req_size_i == 2'b11)
                         || (req_addr_i < START_ADDRESS)
                         || (w_last_addr > {1'b0, END_ADDRESS});

    assign w_span  = {2'b00, req_addr_i[1:0]} + {1'b0, w_nbytes};
    assign w_split = (w_span > 4'd4);
    assign w_mask  = w_mask_base << req_addr_i[1:0];
    assign w_lanes = {{DATA_WIDTH{1'b0}}, req_wdata_i} << {req_addr_i[1:0], 3'b000};

    // ------------------------------------------------------------------
    // Request and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_mask     <= 8'h00;
            r_lanes    <= '0;
            r_fault    <= 1'b0;
            r_split    <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we_i;
                r_size     <= req_size_i;
                r_unsigned <= req_unsigned_i;
                r_addr     <= req_addr_i;
                r_mask     <= w_mask;
                r_lanes    <= w_lanes;
                r_fault    <= w_fault;
                r_split    <= w_split;
            end
            // Read data trails its address by one cycle
            if (r_state == c_st_acc2) begin
                r_lo <= mem_rd_i;
            end
            if (r_state == c_st_wait) begin
                if (r_split) begin
                    r_hi <= mem_rd_i;
                end else begin
                    r_lo <= mem_rd_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load result alignment and extension
    // ------------------------------------------------------------------
    assign w_shifted   = DATA_WIDTH'({r_hi, r_lo} >> {r_addr[1:0], 3'b000});
    assign w_sext      = ~r_unsigned;
    assign w_word_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'b00:   w_load = {{(DATA_WIDTH-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = {{(DATA_WIDTH-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_fault_o = 1'b0;
        resp_rdata_o = '0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_wd_o     = '0;
        case (r_state)
            c_st_idle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_next_state = w_fault ? c_st_resp : c_st_acc1;
                end
            end
            c_st_acc1: begin
                mem_addr_o   = w_word_addr;
                mem_we_o     = r_we;
                mem_be_o     = r_mask[3:0];
                mem_wd_o     = r_lanes[DATA_WIDTH-1:0];
                w_next_state = r_split ? c_st_acc2 : c_st_wait;
            end
            c_st_acc2: begin
                mem_addr_o   = w_word_addr + DATA_WIDTH'(4);
                mem_we_o     = r_we;
                mem_be_o     = r_mask[7:4];
                mem_wd_o     = r_lanes[2*DATA_WIDTH-1:DATA_WIDTH];
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                w_next_state = c_st_resp;
            end
            c_st_resp: begin
                resp_valid_o = 1'b1;
                resp_fault_o = r_fault;
                if (!r_we && !r_fault) begin
                    resp_rdata_o = w_load;
                end
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized scoreboard bench for load_store_unit against a
//            byte-array reference memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_fault_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = '0;

    load_store_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_fault_o   (resp_fault_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
        int          acc_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         access_cnt = 0;
    logic [7:0] ref_mem[logic [31:0]];
    logic [7:0] dut_mem[logic [31:0]];
    logic [31:0] m_rd;
    logic [31:0] m_a;

    always @(posedge clk_i) cyc++;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        if (dut_mem.exists(a)) return dut_mem[a];
        return init_byte(a);
    endfunction

    // Reference: byte-addressed memory with plain range/size rules
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          nb;
        longint      last;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        last = longint'(addr) + longint'(nb) - 1;
        e.rdata = '0; e.fault = 1'b0; e.acc = 0; e.lat = 1; e.acc_cyc = 0;
        if (size == 2'd3 || addr < 32'h10000 || last > 64'h1FFFF) begin
            e.fault = 1'b1;
            return e;
        end
        e.acc = (int'(addr[1:0]) + nb > 4) ? 2 : 1;
        e.lat = e.acc + 2;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_rd(addr + 32'(i));
            if (!uns && nb < 4 && v[8*nb-1]) begin
                for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
            end
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
        ref_mem[a] = b;
        dut_mem[a] = b;
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) set_byte(a + 32'(i), w[8*i +: 8]);
    endtask

    // Memory seen by the DUT: read word registered for the next cycle
    always @(posedge clk_i) begin
        if (mem_be_o != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                m_a = mem_addr_o + 32'(i);
                m_rd[8*i +: 8] = dut_rd(m_a);
                if (mem_we_o && mem_be_o[i]) dut_mem[m_a] = mem_wd_o[8*i +: 8];
            end
            mem_rd_i <= m_rd;
        end else begin
            mem_rd_i <= $urandom;
        end
    end

    // Monitor: bus hygiene and response scoreboard
    always @(negedge clk_i) begin
        if (rst_i) begin
            access_cnt = 0;
        end else begin
            if (mem_be_o != 4'b0000) begin
                access_cnt++;
                check(mem_addr_o[1:0] == 2'b00, "mem_addr_align", mem_addr_o, {mem_addr_o[31:2], 2'b00});
            end else begin
                check(!mem_we_o && mem_addr_o == 0 && mem_wd_o == 0, "mem_idle_zero",
                      mem_wd_o | mem_addr_o | 32'(mem_we_o), 32'h0);
            end
            if (resp_valid_o) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_resp", resp_rdata_o, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check(resp_fault_o == mon_e.fault, "resp_fault", 32'(resp_fault_o), 32'(mon_e.fault));
                    check(resp_rdata_o == mon_e.rdata, "resp_rdata", resp_rdata_o, mon_e.rdata);
                    check(cyc - mon_e.acc_cyc == mon_e.lat, "latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    check(access_cnt == mon_e.acc, "mem_accesses", 32'(access_cnt), 32'(mon_e.acc));
                end
                access_cnt = 0;
            end else begin
                check(resp_rdata_o == 0 && !resp_fault_o, "resp_quiet", resp_rdata_o | 32'(resp_fault_o), 32'h0);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit expect_resp);
        exp_t e;
        bit   done;
        int   waited;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
        done = 1'b0; waited = 0;
        while (!done && waited < 20) begin
            if (req_ready_o) begin
                e = model(we, size, uns, addr, wdata);
                e.acc_cyc = cyc;
                if (expect_resp) sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                @(negedge clk_i);
            end
        end
        check(done, "accept", 32'(done), 32'h1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check(sb.size() == 0, "drain", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        exp_t        dummy;

        repeat (3) @(negedge clk_i);
        check(req_ready_o && !resp_valid_o && !resp_fault_o && resp_rdata_o == 0,
              "reset_resp", resp_rdata_o, 32'h0);
        check(mem_be_o == 0 && !mem_we_o && mem_addr_o == 0 && mem_wd_o == 0,
              "reset_mem", mem_addr_o | mem_wd_o | 32'(mem_be_o), 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        set_word(32'h10000, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 1'b1);
        drain();
        set_byte(32'h10003, 8'h80);
        issue(1'b0, 2'b00, 1'b0, 32'h10003, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h10003, 32'h0, 1'b1);
        drain();
        issue(1'b1, 2'b10, 1'b0, 32'h10002, 32'h11223344, 1'b1);
        drain();
        check({dut_rd(32'h10005), dut_rd(32'h10004), dut_rd(32'h10003), dut_rd(32'h10002)} == 32'h11223344,
              "split_store_mem",
              {dut_rd(32'h10005), dut_rd(32'h10004), dut_rd(32'h10003), dut_rd(32'h10002)}, 32'h11223344);
        set_word(32'h10000, 32'hAA000000);
        set_word(32'h10004, 32'h000000BB);
        issue(1'b0, 2'b01, 1'b0, 32'h10003, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h0FFFC, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h1FFFE, 32'h55AA55AA, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h10000, 32'h0, 1'b1);
        drain();

        // Reset landing in the second half of a split store
        dummy = model(1'b1, 2'b10, 1'b0, 32'h10002, 32'h11223344);
        issue(1'b1, 2'b10, 1'b0, 32'h10002, 32'h11223344, 1'b0);
        @(negedge clk_i);
        check(mem_addr_o == 32'h10000 && mem_be_o == 4'b1100 && mem_we_o, "acc1_addr_be",
              mem_addr_o ^ 32'(mem_be_o), 32'h10000 ^ 32'hC);
        check(mem_wd_o == 32'h33440000, "acc1_wd", mem_wd_o, 32'h33440000);
        @(negedge clk_i);
        check(mem_addr_o == 32'h10004 && mem_be_o == 4'b0011 && mem_we_o, "acc2_addr_be",
              mem_addr_o ^ 32'(mem_be_o), 32'h10004 ^ 32'h3);
        check(mem_wd_o == 32'h00001122, "acc2_wd", mem_wd_o, 32'h00001122);
        rst_i = 1'b1;
        @(negedge clk_i);
        check(!mem_we_o && mem_be_o == 0 && req_ready_o && !resp_valid_o, "reset_mid_access",
              {26'b0, mem_we_o, mem_be_o, resp_valid_o}, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h10004, 32'h0, 1'b1);
        drain();

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 32'h10000 + 32'($urandom_range(0, 31));
            else if (r == 7) a = 32'h0FFFC + 32'($urandom_range(0, 7));
            else if (r == 8) a = 32'h1FFF8 + 32'($urandom_range(0, 7));
            else             a = $urandom;
            r = $urandom_range(0, 7);
            sz = (r <= 1) ? 2'd0 : (r <= 3) ? 2'd1 : (r <= 6) ? 2'd2 : 2'd3;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
        drain();
        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
